// File: rtl/io_input_port.sv
// Memory-mapped input port: synchronised and debounced switches and keys,
// sticky key-press capture, and a fixed one-cycle registered read path.

module io_debounce_lane #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit SYNC_RST        = 1'b0,
   parameter bit INVERT          = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   input  logic stable,
   output logic stable_nxt
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_lvl;

   // The stable flop lives in the parent so it can see both current and
   // next debounced levels for edge detection.
   always_comb begin
      sync_d     = {sync_q[0], raw};
      in_lvl     = sync_q[1] ^ INVERT;
      stable_nxt = stable;
      cnt_d      = '0;
      if (in_lvl != stable) begin
         if (cnt_q == CNT_MAX) stable_nxt = in_lvl;
         else                  cnt_d      = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {2{SYNC_RST}};
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

module io_input_port #(
   parameter int          NUM_SW          = 10,
   parameter int          NUM_KEY         = 4,
   parameter int          DEBOUNCE_CYCLES = 16,
   parameter logic [15:0] ADDR_SW         = 16'hF000,
   parameter logic [15:0] ADDR_KEY        = 16'hF001,
   parameter logic [15:0] ADDR_KEYCAP     = 16'hF002
) (
   input  logic               I_CLOCK,
   input  logic               I_LOCK,
   input  logic [NUM_SW-1:0]  I_SW,
   input  logic [NUM_KEY-1:0] I_KEY,
   input  logic               I_ReadEnable,
   input  logic [15:0]        I_Addr,
   output logic [15:0]        O_ReadData,
   output logic               O_ReadValid,
   output logic               O_KeyPending
);
   logic [NUM_SW-1:0]  sw_db_q, sw_db_d;
   logic [NUM_KEY-1:0] key_db_q, key_db_d, new_press, cap_q, cap_d;
   logic [15:0]        rd_data_q, rd_data_d;
   logic               rd_valid_q, rd_valid_d, pend_q, pend_d, cap_rd;

   generate
      for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
         io_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_RST(1'b0), .INVERT(1'b0)
         ) u_lane (
            .clk(I_CLOCK), .rst_n(I_LOCK), .raw(I_SW[i]),
            .stable(sw_db_q[i]), .stable_nxt(sw_db_d[i])
         );
      end
      // Keys idle high on the board; invert so internal 1 means pressed.
      for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
         io_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_RST(1'b1), .INVERT(1'b1)
         ) u_lane (
            .clk(I_CLOCK), .rst_n(I_LOCK), .raw(I_KEY[i]),
            .stable(key_db_q[i]), .stable_nxt(key_db_d[i])
         );
      end
   endgenerate

   always_comb begin
      new_press  = key_db_d & ~key_db_q;
      cap_rd     = I_ReadEnable && (I_Addr == ADDR_KEYCAP);
      // A press landing in the same cycle as a clearing read survives.
      cap_d      = cap_rd ? new_press : (cap_q | new_press);
      pend_d     = |cap_d;
      rd_valid_d = I_ReadEnable;
      rd_data_d  = rd_data_q;
      if (I_ReadEnable) begin
         rd_data_d = '0;
         if (I_Addr == ADDR_SW)          rd_data_d = 16'(sw_db_q);
         else if (I_Addr == ADDR_KEY)    rd_data_d = 16'(key_db_q);
         else if (I_Addr == ADDR_KEYCAP) rd_data_d = 16'(cap_q);
      end
   end

   always_ff @(posedge I_CLOCK or negedge I_LOCK) begin
      if (!I_LOCK) begin
         sw_db_q    <= '0;
         key_db_q   <= '0;
         cap_q      <= '0;
         pend_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         sw_db_q    <= sw_db_d;
         key_db_q   <= key_db_d;
         cap_q      <= cap_d;
         pend_q     <= pend_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign O_ReadData   = rd_data_q;
   assign O_ReadValid  = rd_valid_q;
   assign O_KeyPending = pend_q;
endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port: reset, debounce timing, capture/clear,
// same-cycle set/clear, unmapped reads and mid-operation reset.

module tb_io_input_port;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  sw;
   logic [3:0]  key;
   logic        re;
   logic [15:0] addr;
   logic [15:0] rdata;
   logic        rvalid;
   logic        pend;
   int          n_total = 0;
   int          n_pass  = 0;

   io_input_port #(
      .NUM_SW(10), .NUM_KEY(4), .DEBOUNCE_CYCLES(16),
      .ADDR_SW(16'hF000), .ADDR_KEY(16'hF001), .ADDR_KEYCAP(16'hF002)
   ) dut (
      .I_CLOCK(clk), .I_LOCK(rst_n), .I_SW(sw), .I_KEY(key),
      .I_ReadEnable(re), .I_Addr(addr),
      .O_ReadData(rdata), .O_ReadValid(rvalid), .O_KeyPending(pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive a one-cycle read, then check data and valid after the sampling edge.
   task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
      re   = 1'b1;
      addr = a;
      tick(1);
      re   = 1'b0;
      chk({tag, "_data"}, rdata, exp);
      chk({tag, "_valid"}, 16'(rvalid), 16'h0001);
   endtask

   initial begin
      rst_n = 1'b0;
      sw    = 10'h3FF;
      key   = 4'h0;
      re    = 1'b0;
      addr  = 16'h0000;

      // Reset with everything active on the raw pins
      tick(3);
      chk("rst_data", rdata, 16'h0000);
      chk("rst_valid", 16'(rvalid), 16'h0000);
      chk("rst_pend", 16'(pend), 16'h0000);
      rst_n = 1'b1;
      tick(20);
      rd(16'hF000, 16'h03FF, "sw_rd");
      tick(1);
      chk("sw_valid_drop", 16'(rvalid), 16'h0000);
      chk("sw_data_hold", rdata, 16'h03FF);
      chk("rst_keys_pend", 16'(pend), 16'h0001);
      key = 4'hF;
      tick(20);
      rd(16'hF002, 16'h000F, "rst_keys_cap");
      chk("rst_keys_clr", 16'(pend), 16'h0000);

      // Bouncing KEY[0]: 10 low, 3 high, then held low
      key = 4'hE;
      tick(10);
      key = 4'hF;
      tick(3);
      key = 4'hE;
      tick(16);
      rd(16'hF001, 16'h0000, "db_before");
      chk("db_pend_e17", 16'(pend), 16'h0000);
      tick(1);
      chk("db_pend_e18", 16'(pend), 16'h0001);
      rd(16'hF001, 16'h0001, "db_after");
      rd(16'hF002, 16'h0001, "db_cap");
      chk("db_cap_clr", 16'(pend), 16'h0000);
      key = 4'hF;
      tick(20);

      // Capture of KEY[2] and KEY[1], then clear-on-read twice
      key = 4'h9;
      tick(20);
      key = 4'hF;
      tick(20);
      rd(16'hF002, 16'h0006, "cap1");
      chk("cap1_pend", 16'(pend), 16'h0000);
      rd(16'hF002, 16'h0000, "cap2");

      // KEY[3] press lands on the same edge as a clearing read
      key = 4'hE;
      tick(20);
      key = 4'h6;
      tick(17);
      rd(16'hF002, 16'h0001, "sim_rd1");
      chk("sim_pend_mid", 16'(pend), 16'h0001);
      rd(16'hF002, 16'h0008, "sim_rd2");
      chk("sim_pend_end", 16'(pend), 16'h0000);
      key = 4'hF;
      tick(20);

      // Unmapped addresses leave capture alone
      key = 4'hD;
      tick(20);
      rd(16'hF003, 16'h0000, "unmap1");
      rd(16'h0010, 16'h0000, "unmap2");
      chk("unmap_pend", 16'(pend), 16'h0001);
      rd(16'hF002, 16'h0002, "unmap_cap");
      key = 4'hF;
      tick(20);

      // Reset while a capture read is in flight
      key = 4'h0;
      tick(20);
      chk("mid_pend_pre", 16'(pend), 16'h0001);
      re   = 1'b1;
      addr = 16'hF002;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_valid", 16'(rvalid), 16'h0000);
      chk("mid_pend", 16'(pend), 16'h0000);
      chk("mid_data", rdata, 16'h0000);
      re  = 1'b0;
      key = 4'hF;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      chk("post_valid", 16'(rvalid), 16'h0000);
      rd(16'hF002, 16'h0000, "post_cap");
      chk("post_pend", 16'(pend), 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
